pe_feed_ctrl: RTL and testbench
===============================

// Module: pe_feed_ctrl
// PURPOSE
//  Upstream stage of one PE: owns the image and filter scratchpads and sequences the PE.
//  Streams window pixels with filter taps as img_pixel/filter_value plus acc_en, then drives
//  rst_acc/res_buffer_en/res_index/rst_res_reg/wr_en/wr_adr/wr_file so results land in PE memory.
//  One instance per PE; pixels arrive from the global image distributor over a valid/ready port.
// PARAMETERS
//  IMG_DEPTH     32   image scratchpad entries (circular); power of 2
//  FILT_DEPTH    16   filter scratchpad entries; max filter length
//  MAX_MEM_SIZE  128  PE result memory words; wr_adr wraps modulo this
// PORTS
//  clk           in   1   clock, all logic on posedge
//  rst           in   1   synchronous, active-high reset
//  img_valid     in   1   pixel offered on img_data
//  img_data      in   8   image pixel
//  img_ready     out  1   scratchpad has room (count < IMG_DEPTH)
//  filt_we       in   1   filter scratchpad write strobe (only honoured in IDLE)
//  filt_addr     in   4   filter write address
//  filt_data     in   8   filter tap
//  start         in   1   1-cycle pulse; samples cfg_* and begins (ignored unless IDLE)
//  cfg_filt_len  in   5   taps per window, 1..FILT_DEPTH
//  cfg_stride    in   5   pixels retired per window, 1..cfg_filt_len
//  cfg_windows   in   8   windows to compute, >=1
//  img_pixel     out  8   operand to PE
//  filter_value  out  8   operand to PE
//  acc_en        out  1   operands valid this cycle
//  rst_acc       out  1   clear PE accumulator
//  res_buffer_en out  1   capture mac_out into res_buffer[res_index]
//  res_index     out  8   result slot, window_idx mod 4
//  rst_res_reg   out  1   clear PE result buffer
//  wr_en         out  1   write result buffer to PE memory
//  wr_adr        out  8   PE memory word address
//  wr_file       out  1   1-cycle dump pulse after last write
//  busy          out  1   state != IDLE
//  done          out  1   1-cycle pulse with wr_file
//  stall_cnt     out  32  see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs 0 except img_ready=1; count, pointers, wr_adr, window_idx = 0; state IDLE.
//  Reset mid-run aborts immediately; scratchpad data need not clear, count does.
//  Image push: img_valid&&img_ready writes at wptr, wptr++ (wraps). count += push - retire;
//   push and retire in one cycle are both honoured; img_ready derives from registered count only.
//  FSM: IDLE -start-> WAIT. WAIT: when count >= cfg_filt_len go MAC (tap k=0).
//   MAC: registered outputs img_pixel=img[base+k], filter_value=filt[k], acc_en=1; k++;
//        after k=cfg_filt_len-1 go DRAIN.  DRAIN: 1 idle cycle (PE MAC latency).
//   STORE: res_buffer_en=1, rst_acc=1, res_index=window_idx[1:0]; base += cfg_stride, retire
//        cfg_stride entries; window_idx++. If res_index==3 or last window go FLUSH else WAIT.
//   FLUSH: wr_en=1 with wr_adr; next cycle rst_res_reg=1 and wr_adr++ (wraps at MAX_MEM_SIZE);
//        then WAIT if windows remain else DONE.  DONE: wr_file=1, done=1, -> IDLE.
//  Latency: window with data present = filt_len + 2 cycles (+2 on flush windows).
//  Partial final group (windows not multiple of 4) flushes with unused slots holding 0.
//  wr_adr persists across runs (next run appends); cleared only by rst.
//  Out-of-range cfg (filt_len 0 or > FILT_DEPTH, stride 0 or > filt_len): start ignored.
// CONFIGURATION
//  PE_FEED_STALL_CNT_EN defined: stall_cnt counts cycles spent in WAIT since start (cleared on
//   start, saturates at 2^32-1). Undefined: no counter logic, stall_cnt tied to 0.
// TESTING
//  filt=1,2,3; pixels 1..5; len3 stride1 win3 -> acc_en 3 cyc each; res 14,20,26; one wr_en @0.
//  win5 len2 stride2, 10 pixels -> wr_en @0 (4 results) then @1 (1 result, slots 1..3 = 0).
//  Push 32 pixels, no start -> img_ready=0 at count 32; push while !ready leaves count 32.
//  Feed pixels 1/cycle starting with start -> WAIT stalls until count>=len; STORE push+retire same cycle count exact.
//  rst asserted during MAC -> next cycle all outputs 0, img_ready=1, busy=0; new start runs clean.
//  PE_FEED_STALL_CNT_EN set, pixels delayed 7 cycles after start -> stall_cnt=7 at done.

Source files
------------

// File: rtl/pe_feed_ctrl.sv
// Feed controller for one PE: image/filter scratchpads, tap sequencing and result write-back.
// Optional macro PE_FEED_STALL_CNT_EN adds a saturating counter of data-starved WAIT cycles.
module pe_feed_ctrl #(
    parameter int unsigned IMG_DEPTH    = 32,
    parameter int unsigned FILT_DEPTH   = 16,
    parameter int unsigned MAX_MEM_SIZE = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        img_valid_i,
    input  logic [7:0]  img_data_i,
    output logic        img_ready_o,
    input  logic        filt_we_i,
    input  logic [3:0]  filt_addr_i,
    input  logic [7:0]  filt_data_i,
    input  logic        start_i,
    input  logic [4:0]  cfg_filt_len_i,
    input  logic [4:0]  cfg_stride_i,
    input  logic [7:0]  cfg_windows_i,
    output logic [7:0]  img_pixel_o,
    output logic [7:0]  filter_value_o,
    output logic        acc_en_o,
    output logic        rst_acc_o,
    output logic        res_buffer_en_o,
    output logic [7:0]  res_index_o,
    output logic        rst_res_reg_o,
    output logic        wr_en_o,
    output logic [7:0]  wr_adr_o,
    output logic        wr_file_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] stall_cnt_o
);
    localparam int unsigned IW = $clog2(IMG_DEPTH);
    localparam int unsigned CW = $clog2(IMG_DEPTH + 1);
    localparam int unsigned FW = $clog2(FILT_DEPTH);

    typedef enum logic [2:0] {
        StIdle, StWait, StMac, StDrain, StStore, StFlush, StFlushRst, StDone
    } state_e;

    state_e         state_q;
    logic [7:0]     img_mem  [IMG_DEPTH];
    logic [7:0]     filt_mem [FILT_DEPTH];
    logic [IW-1:0]  wptr_q, base_q, next_base, rd_base, rd_addr;
    logic [CW-1:0]  count_q, count_d, avail_after;
    logic [4:0]     len_q, stride_q, k_q, rd_tap;
    logic [7:0]     windows_q, widx_q, wr_adr_q;
    logic [7:0]     img_pixel_q, filter_value_q, res_index_q;
    logic           acc_en_q, rst_acc_q, res_buffer_en_q, rst_res_reg_q;
    logic           wr_en_q, wr_file_q, done_q;
    logic           push, retire, cfg_ok, start_ok, last_win, grp_full;

    assign img_ready_o = count_q < CW'(IMG_DEPTH);
    assign push        = img_valid_i && img_ready_o;
    assign retire      = (state_q == StStore);
    assign count_d     = count_q + CW'(push) - (retire ? CW'(stride_q) : '0);
    assign avail_after = count_q - CW'(stride_q);

    assign cfg_ok = (cfg_filt_len_i != '0) && (32'(cfg_filt_len_i) <= FILT_DEPTH) &&
                    (cfg_stride_i != '0) && (cfg_stride_i <= cfg_filt_len_i) &&
                    (cfg_windows_i != '0);
    assign start_ok = (state_q == StIdle) && start_i && cfg_ok;

    assign last_win = (widx_q == windows_q - 8'd1);
    assign grp_full = (widx_q[1:0] == 2'd3);

    // A window entered straight from STORE starts at the post-retire base.
    assign next_base = base_q + IW'(stride_q);
    assign rd_base   = (state_q == StStore) ? next_base : base_q;
    assign rd_tap    = (state_q == StMac) ? k_q : 5'd0;
    assign rd_addr   = rd_base + IW'(rd_tap);

    always_ff @(posedge clk_i) begin
        if (push) img_mem[wptr_q] <= img_data_i;
        if (filt_we_i && state_q == StIdle) filt_mem[filt_addr_i] <= filt_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            wptr_q          <= '0;
            base_q          <= '0;
            count_q         <= '0;
            len_q           <= '0;
            stride_q        <= '0;
            k_q             <= '0;
            windows_q       <= '0;
            widx_q          <= '0;
            wr_adr_q        <= '0;
            img_pixel_q     <= '0;
            filter_value_q  <= '0;
            res_index_q     <= '0;
            acc_en_q        <= 1'b0;
            rst_acc_q       <= 1'b0;
            res_buffer_en_q <= 1'b0;
            rst_res_reg_q   <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_file_q       <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            count_q         <= count_d;
            if (push) wptr_q <= wptr_q + IW'(1);
            acc_en_q        <= 1'b0;
            rst_acc_q       <= 1'b0;
            res_buffer_en_q <= 1'b0;
            rst_res_reg_q   <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_file_q       <= 1'b0;
            done_q          <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        len_q     <= cfg_filt_len_i;
                        stride_q  <= cfg_stride_i;
                        windows_q <= cfg_windows_i;
                        widx_q    <= '0;
                        state_q   <= StWait;
                    end
                end
                StWait: begin
                    if (count_q >= CW'(len_q)) begin
                        state_q        <= StMac;
                        acc_en_q       <= 1'b1;
                        img_pixel_q    <= img_mem[rd_addr];
                        filter_value_q <= filt_mem[rd_tap[FW-1:0]];
                        k_q            <= 5'd1;
                    end
                end
                StMac: begin
                    if (k_q == len_q) begin
                        state_q <= StDrain;
                    end else begin
                        acc_en_q       <= 1'b1;
                        img_pixel_q    <= img_mem[rd_addr];
                        filter_value_q <= filt_mem[rd_tap[FW-1:0]];
                        k_q            <= k_q + 5'd1;
                    end
                end
                StDrain: begin
                    state_q         <= StStore;
                    rst_acc_q       <= 1'b1;
                    res_buffer_en_q <= 1'b1;
                    res_index_q     <= {6'd0, widx_q[1:0]};
                end
                StStore: begin
                    base_q <= next_base;
                    widx_q <= widx_q + 8'd1;
                    if (last_win || grp_full) begin
                        state_q <= StFlush;
                        wr_en_q <= 1'b1;
                    end else if (avail_after >= CW'(len_q)) begin
                        state_q        <= StMac;
                        acc_en_q       <= 1'b1;
                        img_pixel_q    <= img_mem[rd_addr];
                        filter_value_q <= filt_mem[rd_tap[FW-1:0]];
                        k_q            <= 5'd1;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StFlush: begin
                    state_q       <= StFlushRst;
                    rst_res_reg_q <= 1'b1;
                    wr_adr_q      <= (wr_adr_q == 8'(MAX_MEM_SIZE - 1)) ? 8'd0 : wr_adr_q + 8'd1;
                end
                StFlushRst: begin
                    if (widx_q == windows_q) begin
                        state_q   <= StDone;
                        done_q    <= 1'b1;
                        wr_file_q <= 1'b1;
                    end else if (count_q >= CW'(len_q)) begin
                        state_q        <= StMac;
                        acc_en_q       <= 1'b1;
                        img_pixel_q    <= img_mem[rd_addr];
                        filter_value_q <= filt_mem[rd_tap[FW-1:0]];
                        k_q            <= 5'd1;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef PE_FEED_STALL_CNT_EN
    logic [31:0] stall_q;
    // Only cycles starved of pixels count; a WAIT cycle that launches a window does not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (state_q == StWait && count_q < CW'(len_q) && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end
    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign img_pixel_o     = img_pixel_q;
    assign filter_value_o  = filter_value_q;
    assign acc_en_o        = acc_en_q;
    assign rst_acc_o       = rst_acc_q;
    assign res_buffer_en_o = res_buffer_en_q;
    assign res_index_o     = res_index_q;
    assign rst_res_reg_o   = rst_res_reg_q;
    assign wr_en_o         = wr_en_q;
    assign wr_adr_o        = wr_adr_q;
    assign wr_file_o       = wr_file_q;
    assign busy_o          = (state_q != StIdle);
    assign done_o          = done_q;
endmodule

// File: tb/tb_pe_feed_ctrl.sv
// Bench for pe_feed_ctrl: a stream/queue model of windows plus an emulated PE, checked every cycle.
module tb_pe_feed_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        img_valid = 1'b0;
    logic [7:0]  img_data = '0;
    logic        img_ready;
    logic        filt_we = 1'b0;
    logic [3:0]  filt_addr = '0;
    logic [7:0]  filt_data = '0;
    logic        start = 1'b0;
    logic [4:0]  cfg_len = '0;
    logic [4:0]  cfg_stride = '0;
    logic [7:0]  cfg_win = '0;
    logic [7:0]  img_pixel, filter_value, res_index, wr_adr;
    logic        acc_en, rst_acc, res_buffer_en, rst_res_reg, wr_en, wr_file, busy, done;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    pe_feed_ctrl dut (
        .clk_i(clk), .rst_i(rst), .img_valid_i(img_valid), .img_data_i(img_data),
        .img_ready_o(img_ready), .filt_we_i(filt_we), .filt_addr_i(filt_addr),
        .filt_data_i(filt_data), .start_i(start), .cfg_filt_len_i(cfg_len),
        .cfg_stride_i(cfg_stride), .cfg_windows_i(cfg_win), .img_pixel_o(img_pixel),
        .filter_value_o(filter_value), .acc_en_o(acc_en), .rst_acc_o(rst_acc),
        .res_buffer_en_o(res_buffer_en), .res_index_o(res_index), .rst_res_reg_o(rst_res_reg),
        .wr_en_o(wr_en), .wr_adr_o(wr_adr), .wr_file_o(wr_file), .busy_o(busy),
        .done_o(done), .stall_cnt_o(stall_cnt)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Model: pixel stream queue, filter copy, window bookkeeping; PE emulation from DUT outputs.
    logic [7:0] pq[$];
    int     fm[16];
    bit     m_busy = 0;
    int     m_count = 0;
    int     m_len = 0, m_stride = 0, m_win = 0, m_widx = 0, m_t = 0, m_wadr = 0;
    longint m_esum = 0;
    longint exp_buf[4];
    bit     flush_pend = 0;
    bit     rst_prev = 0;
    longint pe_acc = 0;
    longint pe_buf[4];
    longint pe_mem[128][4];
    int     acc_cycles = 0;

    always @(negedge clk) begin
        bit was_busy;
        logic [7:0] tmp;
        was_busy = m_busy;
        if (rst_prev) begin
            chk("rst_outs", {img_pixel, filter_value, acc_en, rst_acc, res_buffer_en, res_index,
                             rst_res_reg, wr_en, wr_adr, wr_file, busy, done}, 64'd0);
            chk("rst_stall", stall_cnt, 0);
        end
        chk("img_ready", img_ready, m_count < 32);
        chk("busy", busy, m_busy);
        chk("done_wr_file", done, wr_file);
        if (!m_busy) chk("idle_quiet", {acc_en, res_buffer_en, wr_en, rst_acc, rst_res_reg}, 0);
        if (rst) begin
            rst_prev = 1; m_busy = 0; m_count = 0; pq.delete(); m_wadr = 0; m_t = 0;
            m_esum = 0; flush_pend = 0; pe_acc = 0;
            for (int i = 0; i < 4; i++) begin exp_buf[i] = 0; pe_buf[i] = 0; end
        end else begin
            rst_prev = 0;
            if (acc_en) begin
                if (m_t >= pq.size() || m_t >= m_len) begin
                    chk("tap_in_window", m_t, pq.size());
                end else begin
                    chk("img_pixel", img_pixel, pq[m_t]);
                    chk("filter_value", filter_value, fm[m_t]);
                    m_esum += longint'(pq[m_t]) * fm[m_t];
                end
                m_t++;
                pe_acc += longint'(img_pixel) * longint'(filter_value);
                acc_cycles++;
            end
            if (res_buffer_en) begin
                chk("taps_per_window", m_t, m_len);
                chk("res_index", res_index, m_widx % 4);
                chk("rst_acc_with_store", rst_acc, 1);
                exp_buf[m_widx % 4] = m_esum;
                flush_pend = (m_widx % 4 == 3) || (m_widx == m_win - 1);
                m_widx++; m_t = 0; m_esum = 0;
                for (int i = 0; i < m_stride; i++) if (pq.size() > 0) tmp = pq.pop_front();
                m_count -= m_stride;
                pe_buf[res_index[1:0]] = pe_acc;
            end
            if (rst_acc) pe_acc = 0;
            if (wr_en) begin
                chk("flush_due", flush_pend, 1);
                chk("wr_adr", wr_adr, m_wadr);
                for (int i = 0; i < 4; i++) chk("slot", pe_buf[i], exp_buf[i]);
                for (int i = 0; i < 4; i++) begin pe_mem[wr_adr[6:0]][i] = pe_buf[i]; exp_buf[i] = 0; end
                m_wadr = (m_wadr + 1) % 128;
                flush_pend = 0;
            end
            if (rst_res_reg) for (int i = 0; i < 4; i++) pe_buf[i] = 0;
            if (done) begin
                chk("windows_done", m_widx, m_win);
                chk("flush_left", flush_pend, 0);
                m_busy = 0;
            end
            if (img_valid && m_count < 32) begin pq.push_back(img_data); m_count++; end
            if (filt_we && !was_busy) fm[filt_addr] = filt_data;
            if (start && !was_busy && cfg_len >= 1 && cfg_len <= 16 && cfg_stride >= 1 &&
                cfg_stride <= cfg_len && cfg_win >= 1) begin
                m_busy = 1; m_len = cfg_len; m_stride = cfg_stride; m_win = cfg_win;
                m_widx = 0; m_t = 0; m_esum = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic push_px(input int v);
        img_valid = 1; img_data = 8'(v); tick(); img_valid = 0;
    endtask

    task automatic write_filt(input int a, input int v);
        filt_we = 1; filt_addr = 4'(a); filt_data = 8'(v); tick(); filt_we = 0;
    endtask

    task automatic go(input int len, input int stride, input int win);
        start = 1; cfg_len = 5'(len); cfg_stride = 5'(stride); cfg_win = 8'(win);
        tick(); start = 0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        chk(nm, seen, 1);
        tick();
    endtask

    task automatic chk_word(input string nm, input int adr, input longint a, input longint b,
                            input longint c, input longint d);
        chk(nm, pe_mem[adr][0], a); chk(nm, pe_mem[adr][1], b);
        chk(nm, pe_mem[adr][2], c); chk(nm, pe_mem[adr][3], d);
    endtask

    initial begin
        int a0, acc, found;
        for (int i = 0; i < 128; i++) for (int j = 0; j < 4; j++) pe_mem[i][j] = 0;
        for (int i = 0; i < 16; i++) fm[i] = 0;
        for (int i = 0; i < 4; i++) begin exp_buf[i] = 0; pe_buf[i] = 0; end
        do_reset();

        // Three overlapping windows of length 3.
        write_filt(0, 1); write_filt(1, 2); write_filt(2, 3);
        for (int v = 1; v <= 5; v++) push_px(v);
        a0 = acc_cycles;
        go(3, 1, 3);
        wait_done("t1_done");
        chk("t1_acc_cycles", acc_cycles - a0, 9);
        chk_word("t1_word0", 0, 14, 20, 26, 0);

        // Five windows, two flush groups, second group partial.
        do_reset();
        for (int v = 1; v <= 10; v++) push_px(v);
        go(2, 2, 5);
        wait_done("t2_done");
        chk_word("t2_word0", 0, 5, 11, 17, 23);
        chk_word("t2_word1", 1, 29, 0, 0, 0);

        // No reset: next run appends at address 2.
        push_px(3); push_px(4);
        go(2, 2, 1);
        wait_done("t2b_done");
        chk_word("t2b_word2", 2, 11, 0, 0, 0);

        // Illegal configurations are ignored.
        do_reset();
        go(0, 1, 1);  chk("bad_len0", busy, 0);
        go(3, 4, 1);  chk("bad_stride", busy, 0);
        go(17, 1, 1); chk("bad_len17", busy, 0);
        go(2, 0, 1);  chk("bad_stride0", busy, 0);

        // Fill the scratchpad without starting.
        acc = 0;
        for (int i = 0; i < 33; i++) begin
            if (img_ready) acc++;
            img_valid = 1; img_data = 8'(i); tick();
        end
        img_valid = 0;
        chk("fill_accepted", acc, 32);
        chk("fill_ready_low", img_ready, 0);
        tick();
        chk("fill_ready_still_low", img_ready, 0);

        // Pixels trickle in alongside the run; then refill to expose the exact count.
        do_reset();
        write_filt(0, 1); write_filt(1, 2); write_filt(2, 3); write_filt(3, 4);
        start = 1; cfg_len = 5'd4; cfg_stride = 5'd2; cfg_win = 8'd3;
        img_valid = 1; img_data = 8'd1; tick(); start = 0;
        for (int v = 2; v <= 10; v++) begin img_data = 8'(v); tick(); end
        img_valid = 0;
        wait_done("t5_done");
        chk_word("t5_word0", 0, 30, 50, 70, 0);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (img_ready) acc++;
            img_valid = 1; img_data = 8'(100 + i); tick();
        end
        img_valid = 0;
        chk("t5_refill", acc, 28);

        // Reset in the middle of a window, then a clean rerun.
        do_reset();
        for (int v = 1; v <= 5; v++) push_px(v);
        go(3, 1, 3);
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (acc_en) found = 1; else tick();
        end
        chk("t6_reached_mac", found, 1);
        rst = 1; tick(); rst = 0;
        chk("t6_acc_en", acc_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ready", img_ready, 1);
        for (int v = 1; v <= 5; v++) push_px(v);
        go(3, 1, 3);
        wait_done("t6_done");
        chk_word("t6_word0", 0, 14, 20, 26, 0);

        // Pixel arrives seven cycles after start.
        do_reset();
        go(1, 1, 1);
        repeat (6) tick();
        push_px(9);
        wait_done("t7_done");
        chk_word("t7_word0", 0, 9, 0, 0, 0);
`ifdef PE_FEED_STALL_CNT_EN
        chk("t7_stall_cnt", stall_cnt, 7);
`else
        chk("t7_stall_cnt", stall_cnt, 0);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
